// File: rtl/ripple_mon_pkg.sv
// Shared types and constants for the ripple-counter monitor.
// Holds the FSM state encoding, the count width and the modulo-16 successor helper.
package ripple_mon_pkg;

  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } mon_state_t;

  function automatic logic [COUNT_W-1:0] count_next(input logic [COUNT_W-1:0] v);
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage flop synchronizer for a bus whose bits are sampled as a group.
// The second stage drives the output q.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/ripple_count_monitor.sv
// Filters an asynchronous 4-bit ripple count, checks that it only ever steps by +1,
// and reports wraps, compare matches and illegal jumps.
module ripple_count_monitor
  import ripple_mon_pkg::*;
#(
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] q_in,
  input  logic [COUNT_W-1:0] cmp_val,
  input  logic               cmp_en,
  input  logic               clr,
  output logic [COUNT_W-1:0] q_stable,
  output logic               stable_valid,
  output logic               wrap_pulse,
  output logic               match_pulse,
  output logic               err_sticky,
  output logic [WRAP_W-1:0]  wrap_count,
  output logic               wrap_sat,
  output mon_state_t         dbg_state
);

  localparam logic [2:0]        STAB_MAX = 3'(STABLE_CYCLES);
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  logic [COUNT_W-1:0] s2;

  sync_2ff #(.WIDTH(COUNT_W)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (q_in),
    .q     (s2)
  );

  // Synchronizer stages hold reset zeros, not samples, until two edges have passed.
  logic [1:0]         prime_q, prime_d;
  logic [COUNT_W-1:0] cand_q, cand_d;
  logic [2:0]         stab_q, stab_d;
  logic               accept;

  always_comb begin
    prime_d = {prime_q[0], 1'b1};
    cand_d  = cand_q;
    stab_d  = stab_q;
    if (prime_q[1]) begin
      if (s2 != cand_q) begin
        cand_d = s2;
        stab_d = 3'd1;
      end else if (stab_q != STAB_MAX) begin
        stab_d = stab_q + 3'd1;
      end
    end
  end

  assign accept = (stab_q == STAB_MAX);

  mon_state_t         state_q, state_d;
  logic [COUNT_W-1:0] q_stable_q, q_stable_d;
  logic               stable_valid_q, stable_valid_d;
  logic               wrap_pulse_q, wrap_pulse_d;
  logic               match_pulse_q, match_pulse_d;
  logic               err_q, err_d;
  logic [WRAP_W-1:0]  wrap_count_q, wrap_count_d;
  logic               wrap_sat_q, wrap_sat_d;
  logic               wrap_inc;

  always_comb begin
    state_d        = state_q;
    q_stable_d     = q_stable_q;
    stable_valid_d = stable_valid_q;
    wrap_pulse_d   = 1'b0;
    match_pulse_d  = 1'b0;
    err_d          = err_q;
    wrap_count_d   = wrap_count_q;
    wrap_inc       = 1'b0;

    case (state_q)
      ACQUIRE: begin
        if (accept) begin
          q_stable_d     = cand_q;
          stable_valid_d = 1'b1;
          state_d        = TRACK;
        end
      end
      TRACK: begin
        if (accept && (cand_q != q_stable_q)) begin
          q_stable_d = cand_q;
          if (cand_q == count_next(q_stable_q)) begin
            if (cand_q == '0) begin
              wrap_pulse_d = 1'b1;
              wrap_inc     = 1'b1;
            end
            if (cmp_en && (cand_q == cmp_val)) match_pulse_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = FAULT;
          end
        end
      end
      FAULT: begin
        if (accept) q_stable_d = cand_q;
        if (clr) begin
          stable_valid_d = 1'b0;
          state_d        = ACQUIRE;
        end
      end
      default: state_d = ACQUIRE;
    endcase

    // clr wins over a same-edge wrap increment; the pulse itself still goes out.
    if (wrap_inc && (wrap_count_q != WRAP_MAX)) wrap_count_d = wrap_count_q + 1'b1;
    if (clr) begin
      wrap_count_d = '0;
      err_d        = 1'b0;
    end
    wrap_sat_d = (wrap_count_d == WRAP_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_q        <= '0;
      cand_q         <= '0;
      stab_q         <= '0;
      state_q        <= ACQUIRE;
      q_stable_q     <= '0;
      stable_valid_q <= 1'b0;
      wrap_pulse_q   <= 1'b0;
      match_pulse_q  <= 1'b0;
      err_q          <= 1'b0;
      wrap_count_q   <= '0;
      wrap_sat_q     <= 1'b0;
    end else begin
      prime_q        <= prime_d;
      cand_q         <= cand_d;
      stab_q         <= stab_d;
      state_q        <= state_d;
      q_stable_q     <= q_stable_d;
      stable_valid_q <= stable_valid_d;
      wrap_pulse_q   <= wrap_pulse_d;
      match_pulse_q  <= match_pulse_d;
      err_q          <= err_d;
      wrap_count_q   <= wrap_count_d;
      wrap_sat_q     <= wrap_sat_d;
    end
  end

  assign q_stable     = q_stable_q;
  assign stable_valid = stable_valid_q;
  assign wrap_pulse   = wrap_pulse_q;
  assign match_pulse  = match_pulse_q;
  assign err_sticky   = err_q;
  assign wrap_count   = wrap_count_q;
  assign wrap_sat     = wrap_sat_q;
  assign dbg_state    = state_q;

endmodule
